ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
//  - Consumes forwardA/forwardB to select ALU operands from ID/EX, EX/MEM or MEM/WB.
//  - Computes the single-cycle ALU result.
//  - Hosts an iterative multiply/divide unit with HI/LO registers.
//  - Raises md_stall when the pipeline must hold.

---
 rtl/ex_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with operand forwarding, a single-cycle ALU and an
//           iterative multiply/divide unit that owns the HI/LO registers.
//           Define MD_DIV_EN to build the divider; without it, DIV/DIVU are no-ops.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] idex_rs_data,
    input  logic [DATA_W-1:0] idex_rt_data,
    input  logic [DATA_W-1:0] idex_imm,
    input  logic [4:0]        idex_shamt,
    input  logic              idex_alusrc,
    input  logic [3:0]        idex_alu_ctrl,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic [DATA_W-1:0] memwb_wdata,
    input  logic              md_start,
    input  logic [2:0]        md_op,
    input  logic [1:0]        hilo_sel,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] ex_rt_fwd,
    output logic              zero,
    output logic              overflow,
    output logic              md_busy,
    output logic              md_stall
);
    typedef enum logic {IDLE, RUN} md_state_t;

    md_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;

    logic [DATA_W-1:0]   src_a, src_b, alu_res, sum, diff, a_mag, b_mag;
    logic                ovf, sa, sb, sgn_op, mul_ok, div_ok, last;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_p, div_p, step_p, prod;

    assign src_a     = forwardA == 2'd2 ? exmem_alu_result : forwardA == 2'd1 ? memwb_wdata : idex_rs_data;
    assign ex_rt_fwd = forwardB == 2'd2 ? exmem_alu_result : forwardB == 2'd1 ? memwb_wdata : idex_rt_data;
    assign src_b     = idex_alusrc ? idex_imm : ex_rt_fwd;
    assign sum       = src_a + src_b;
    assign diff      = src_a - src_b;

    // Single-cycle ALU; signed overflow is only reported for ADD and SUB
    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (idex_alu_ctrl)
            4'd0: begin
                alu_res = sum;
                ovf     = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            4'd1: begin
                alu_res = diff;
                ovf     = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = ~(src_a | src_b);
            4'd6:    alu_res = DATA_W'($signed(src_a) < $signed(src_b));
            4'd7:    alu_res = DATA_W'(src_a < src_b);
            4'd8:    alu_res = src_b << idex_shamt;
            4'd9:    alu_res = src_b >> idex_shamt;
            4'd10:   alu_res = $signed(src_b) >>> idex_shamt;
            4'd11:   alu_res = {src_b[15:0], {(DATA_W-16){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    assign zero      = alu_res == '0;
    assign overflow  = ovf;
    assign ex_result = hilo_sel == 2'd1 ? hi_q : hilo_sel == 2'd2 ? lo_q : alu_res;
    assign md_busy   = state_q == RUN;
    assign md_stall  = md_busy & (md_start | hilo_sel == 2'd1 | hilo_sel == 2'd2);

    assign sgn_op = md_op == 3'd1 || md_op == 3'd3;
    assign sa     = sgn_op & src_a[DATA_W-1];
    assign sb     = sgn_op & src_b[DATA_W-1];
    assign a_mag  = sa ? -src_a : src_a;
    assign b_mag  = sb ? -src_b : src_b;
    assign mul_ok = md_op == 3'd1 || md_op == 3'd2;

    // Shift-add multiply step: conditionally add the multiplicand into the upper half, shift right
    assign mul_sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign mul_p   = {mul_sum, p_q[DATA_W-1:1]};

`ifdef MD_DIV_EN
    logic [DATA_W:0] div_sh, div_dif;
    // Restoring divide step: shift the next dividend bit into the remainder, subtract if it fits
    assign div_sh  = p_q[2*DATA_W-1:DATA_W-1];
    assign div_dif = div_sh - {1'b0, b_q};
    assign div_p   = div_dif[DATA_W] ? {div_sh[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                                     : {div_dif[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
    assign div_ok  = md_op == 3'd3 || md_op == 3'd4;
`else
    assign div_p   = '0;
    assign div_ok  = 1'b0;
`endif

    assign step_p = div_q ? div_p : mul_p;
    assign prod   = neg_q ? -step_p : step_p;
    assign last   = state_q == RUN && cnt_q == CNT_W'(DATA_W - 1);

    // MD next state: accept ops in IDLE, iterate in RUN, write sign-corrected HI/LO on the last step.
    // A zero divisor never flips the quotient sign, so LO stays all ones and HI restores srcA.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (md_start && (mul_ok || div_ok)) begin
                state_d = RUN;
                cnt_d   = '0;
                p_d     = {{DATA_W{1'b0}}, a_mag};
                b_d     = b_mag;
                div_d   = div_ok;
                neg_d   = (sa ^ sb) & (|src_b);
                rneg_d  = sa;
            end else if (md_start && md_op == 3'd5) begin
                hi_d = src_a;
            end else if (md_start && md_op == 3'd6) begin
                lo_d = src_a;
            end
        end else begin
            p_d   = step_p;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                state_d = IDLE;
                hi_d    = div_q ? (rneg_q ? -step_p[2*DATA_W-1:DATA_W] : step_p[2*DATA_W-1:DATA_W])
                                : prod[2*DATA_W-1:DATA_W];
                lo_d    = div_q ? (neg_q ? -step_p[DATA_W-1:0] : step_p[DATA_W-1:0])
                                : prod[DATA_W-1:0];
            end
        end
    end

    // MD state and HI/LO registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table and randomized checks of ex_stage against a behavioural model
module tb_ex_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] rs, rt, imm, exmem, memwb;
    logic [4:0]   shamt;
    logic         alusrc;
    logic [3:0]   op;
    logic [1:0]   fa, fb;
    logic         md_start;
    logic [2:0]   md_op;
    logic [1:0]   hilo_sel;
    logic [W-1:0] ex_result, ex_rt_fwd;
    logic         zero, overflow, md_busy, md_stall;

    int           errs = 0;
    int           checks = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    ex_stage #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_rs_data(rs), .idex_rt_data(rt), .idex_imm(imm), .idex_shamt(shamt),
        .idex_alusrc(alusrc), .idex_alu_ctrl(op), .forwardA(fa), .forwardB(fb),
        .exmem_alu_result(exmem), .memwb_wdata(memwb),
        .md_start(md_start), .md_op(md_op), .hilo_sel(hilo_sel),
        .ex_result(ex_result), .ex_rt_fwd(ex_rt_fwd), .zero(zero), .overflow(overflow),
        .md_busy(md_busy), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fwd_m(input logic [1:0] s, input logic [W-1:0] id,
                                           input logic [W-1:0] em, input logic [W-1:0] mw);
        if (s == 2'd2) return em;
        if (s == 2'd1) return mw;
        return id;
    endfunction

    // Reference ALU from arithmetic on wide signed integers; returns {overflow, result}
    function automatic logic [W:0] alu_m(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
        longint la = longint'($signed(a));
        longint lb = longint'($signed(b));
        longint s = 0;
        logic [W-1:0] r = '0;
        logic v = 1'b0;
        case (o)
            4'd0: begin s = la + lb; r = W'(s); v = s != longint'(int'(s)); end
            4'd1: begin s = la - lb; r = W'(s); v = s != longint'(int'(s)); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = W'(la < lb);
            4'd7: r = W'(a < b);
            4'd8: r = b << sh;
            4'd9: r = b >> sh;
            4'd10: r = W'(lb >>> sh);
            4'd11: r = (b & 32'hFFFF) << 16;
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    // Reference MD unit: updates the model HI/LO and reports the expected busy latency
    task automatic md_m(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        longint la = longint'($signed(a));
        longint lb = longint'($signed(b));
        logic [63:0] p;
        lat = 0;
        case (o)
            3'd1: begin p = la * lb; {hi_m, lo_m} = p; lat = W; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = p; lat = W; end
`ifdef MD_DIV_EN
            3'd3: begin
                lat = W;
                if (b == 0) begin hi_m = a; lo_m = '1; end
                else begin hi_m = W'(la % lb); lo_m = W'(la / lb); end
            end
            3'd4: begin
                lat = W;
                if (b == 0) begin hi_m = a; lo_m = '1; end
                else begin hi_m = a % b; lo_m = a / b; end
            end
`endif
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic md_issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        fa = 2'd0; fb = 2'd0; alusrc = 1'b0; rs = a; rt = b; md_op = o; md_start = 1'b1; hilo_sel = 2'd0;
        @(posedge clk);
        #1;
        md_start = 1'b0;
    endtask

    task automatic md_wait(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md_busy) break;
            n++;
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        hilo_sel = 2'd1;
        #1 chk({tag, " HI"}, ex_result, eh);
        chk({tag, " stall"}, md_stall, 1'b0);
        hilo_sel = 2'd2;
        #1 chk({tag, " LO"}, ex_result, el);
        hilo_sel = 2'd0;
    endtask

    typedef struct {
        logic [1:0]   fa, fb;
        logic         alusrc;
        logic [3:0]   op;
        logic [W-1:0] rs, rt, imm;
        logic [4:0]   shamt;
        logic [W-1:0] exmem, memwb, exp_res, exp_rt;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n, lat;
        logic [W:0] ref_v;
        logic [W-1:0] ea, eb, ert, a, b;
        logic [2:0] o;

        tbl[0]  = '{2'd2, 2'd0, 1'b1, 4'd0,  32'h99, 32'h33, 32'h5, 5'd0, 32'h10, 32'h0, 32'h15, 32'h33, 1'b0};
        tbl[1]  = '{2'd1, 2'd0, 1'b1, 4'd0,  32'h99, 32'h33, 32'h5, 5'd0, 32'h10, 32'h7, 32'hC, 32'h33, 1'b0};
        tbl[2]  = '{2'd0, 2'd0, 1'b0, 4'd1,  32'h80000000, 32'h1, 32'h0, 5'd0, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h1, 1'b1};
        tbl[3]  = '{2'd0, 2'd0, 1'b0, 4'd6,  32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 32'h0, 32'h0, 32'h1, 32'h1, 1'b0};
        tbl[4]  = '{2'd0, 2'd0, 1'b0, 4'd7,  32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0};
        tbl[5]  = '{2'd0, 2'd0, 1'b0, 4'd0,  32'h7FFFFFFF, 32'h1, 32'h0, 5'd0, 32'h0, 32'h0, 32'h80000000, 32'h1, 1'b1};
        tbl[6]  = '{2'd3, 2'd2, 1'b0, 4'd0,  32'h5, 32'h7, 32'h0, 5'd0, 32'h100, 32'h200, 32'h105, 32'h100, 1'b0};
        tbl[7]  = '{2'd0, 2'd1, 1'b0, 4'd2,  32'hFF0F, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0FF0, 32'h0F00, 32'h0FF0, 1'b0};
        tbl[8]  = '{2'd0, 2'd0, 1'b0, 4'd5,  32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        tbl[9]  = '{2'd0, 2'd0, 1'b0, 4'd10, 32'h1, 32'h80000000, 32'h0, 5'd4, 32'h0, 32'h0, 32'hF8000000, 32'h80000000, 1'b0};
        tbl[10] = '{2'd0, 2'd0, 1'b0, 4'd9,  32'h1, 32'h80000000, 32'h0, 5'd4, 32'h0, 32'h0, 32'h08000000, 32'h80000000, 1'b0};
        tbl[11] = '{2'd0, 2'd0, 1'b0, 4'd8,  32'h1, 32'h3, 32'h0, 5'd31, 32'h0, 32'h0, 32'h80000000, 32'h3, 1'b0};
        tbl[12] = '{2'd0, 2'd0, 1'b1, 4'd11, 32'h1, 32'h0, 32'h1234ABCD, 5'd0, 32'h0, 32'h0, 32'hABCD0000, 32'h0, 1'b0};
        tbl[13] = '{2'd0, 2'd0, 1'b0, 4'd13, 32'h5, 32'h6, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h6, 1'b0};
        tbl[14] = '{2'd0, 2'd0, 1'b0, 4'd4,  32'hF0F0, 32'hFFFF, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0F0F, 32'hFFFF, 1'b0};
        tbl[15] = '{2'd0, 2'd0, 1'b0, 4'd1,  32'h5, 32'h5, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h5, 1'b0};

        rs = '0; rt = '0; imm = '0; exmem = '0; memwb = '0; shamt = '0; alusrc = 1'b0; op = '0;
        fa = '0; fb = '0; md_start = 1'b0; md_op = '0; hilo_sel = '0;

        repeat (2) @(negedge clk);
        chk("reset busy", md_busy, 1'b0);
        chk("reset stall", md_stall, 1'b0);
        hilo_sel = 2'd1;
        #1 chk("reset HI", ex_result, '0);
        hilo_sel = 2'd2;
        #1 chk("reset LO", ex_result, '0);
        hilo_sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            fa = tbl[i].fa; fb = tbl[i].fb; alusrc = tbl[i].alusrc; op = tbl[i].op;
            rs = tbl[i].rs; rt = tbl[i].rt; imm = tbl[i].imm; shamt = tbl[i].shamt;
            exmem = tbl[i].exmem; memwb = tbl[i].memwb;
            hilo_sel = (i % 3 == 0) ? 2'd3 : 2'd0;
            #1;
            chk($sformatf("vec%0d result", i), ex_result, tbl[i].exp_res);
            chk($sformatf("vec%0d rt_fwd", i), ex_rt_fwd, tbl[i].exp_rt);
            chk($sformatf("vec%0d zero", i), zero, tbl[i].exp_res == '0);
            chk($sformatf("vec%0d overflow", i), overflow, tbl[i].exp_ovf);
        end
        hilo_sel = 2'd0;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            fa = 2'($urandom); fb = 2'($urandom); alusrc = 1'($urandom); op = 4'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            imm = $urandom; exmem = $urandom; memwb = $urandom; shamt = 5'($urandom);
            ea = fwd_m(fa, rs, exmem, memwb);
            ert = fwd_m(fb, rt, exmem, memwb);
            eb = alusrc ? imm : ert;
            ref_v = alu_m(op, ea, eb, shamt);
            #1;
            chk($sformatf("rnd%0d op%0d result", i, op), ex_result, ref_v[W-1:0]);
            chk($sformatf("rnd%0d rt_fwd", i), ex_rt_fwd, ert);
            chk($sformatf("rnd%0d zero", i), zero, ref_v[W-1:0] == '0);
            chk($sformatf("rnd%0d overflow", i), overflow, ref_v[W]);
        end

        md_m(3'd1, 32'hFFFFFFFD, 32'd5, lat);
        md_issue(3'd1, 32'hFFFFFFFD, 32'd5);
        chk("mult busy", md_busy, 1'b1);
        hilo_sel = 2'd2;
        #1 chk("mflo stall", md_stall, 1'b1);
        hilo_sel = 2'd0; md_start = 1'b1; md_op = 3'd2;
        #1 chk("start stall", md_stall, 1'b1);
        md_start = 1'b0;
        #1 chk("idle stall", md_stall, 1'b0);
        md_wait(n);
        chk("mult latency", n, 32);
        chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

`ifdef MD_DIV_EN
        md_m(3'd3, 32'hFFFFFFF9, 32'd2, lat);
        md_issue(3'd3, 32'hFFFFFFF9, 32'd2);
        md_wait(n);
        chk("div latency", n, 32);
        chk_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_m(3'd4, 32'd7, 32'd0, lat);
        md_issue(3'd4, 32'd7, 32'd0);
        md_wait(n);
        chk("divu0 latency", n, 32);
        chk_hilo("divu0", 32'd7, 32'hFFFFFFFF);
`else
        md_m(3'd5, 32'h1111, 32'd0, lat);
        md_issue(3'd5, 32'h1111, 32'd0);
        md_m(3'd6, 32'h2222, 32'd0, lat);
        md_issue(3'd6, 32'h2222, 32'd0);
        md_m(3'd3, 32'd7, 32'd2, lat);
        md_issue(3'd3, 32'd7, 32'd2);
        chk("nodiv busy", md_busy, 1'b0);
        md_wait(n);
        chk("nodiv latency", n, 0);
        chk_hilo("nodiv", 32'h1111, 32'h2222);
`endif

        md_m(3'd5, 32'hABCD, 32'd0, lat);
        md_issue(3'd5, 32'hABCD, 32'd0);
        hilo_sel = 2'd1;
        #1 chk("mfhi after mthi", ex_result, 32'hABCD);
        chk("mfhi stall", md_stall, 1'b0);
        hilo_sel = 2'd0;

        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom);
            a = ($urandom_range(0, 1) == 0) ? W'($signed(8'($urandom))) : $urandom;
            b = ($urandom_range(0, 4) == 0) ? '0 : ($urandom_range(0, 1) == 0) ? W'($signed(6'($urandom))) : $urandom;
            md_m(o, a, b, lat);
            md_issue(o, a, b);
            md_wait(n);
            chk($sformatf("md%0d op%0d latency", i, o), n, lat);
            chk_hilo($sformatf("md%0d op%0d", i, o), hi_m, lo_m);
        end

        md_issue(3'd5, 32'h6666, 32'd0);
        md_issue(3'd6, 32'h5555, 32'd0);
        md_issue(3'd2, 32'h12345, 32'h777);
        repeat (10) @(negedge clk);
        op = 4'd0;
        rst_n = 1'b0;
        #1 chk("abort busy", md_busy, 1'b0);
        chk("reset comb result", ex_result, 32'h12ABC);
        hilo_sel = 2'd1;
        #1 chk("abort HI", ex_result, '0);
        hilo_sel = 2'd2;
        #1 chk("abort LO", ex_result, '0);
        hilo_sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = '0; lo_m = '0;
        md_m(3'd2, 32'd3, 32'd4, lat);
        md_issue(3'd2, 32'd3, 32'd4);
        md_wait(n);
        chk("multu latency", n, 32);
        chk_hilo("multu 3*4", 32'd0, 32'd12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
